// File: rtl/nibble_payload_injector.sv
// Merges FIFO-buffered payload words, nibble by nibble, into the user slots of
// an upstream frame nibble stream, with a fixed two-cycle latency.
module nibble_payload_injector #(
    parameter int          DATA_W       = 8,
    parameter int          DEPTH_LOG2   = 10,
    parameter int          START_THRESH = 512,
    parameter int          ALIGN_DROP   = 1,
    parameter logic [3:0]  PAD_NIBBLE   = 4'h0
) (
    input  logic                  eth_clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic [3:0]            nibble,
    input  logic                  nibble_user_data,
    input  logic                  nibble_valid,
    output logic [3:0]            out_nibble,
    output logic                  out_valid,
    output logic                  start_send,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NN    = DATA_W / 4;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_in_ready;

    logic [3:0]            r_d1_nib;
    logic                  r_d1_user;
    logic                  r_d1_valid;
    logic [3:0]            r_out_nibble;
    logic                  r_out_valid;
    logic                  r_underrun;
    logic [15:0]           r_underrun_cnt;
    logic                  r_start_send;

    logic [DATA_W-1:0]     r_cur;
    logic                  r_cur_v;
    logic [IDX_W-1:0]      r_idx;

    logic                  w_slot_user;
    logic                  w_eof;
    logic [DATA_W-1:0]     w_cur_shift;
    logic [3:0]            w_out_nib;
    logic                  w_under;
    logic [IDX_W-1:0]      w_idx_nx;
    logic                  w_clr;
    logic                  w_pop;
    logic                  w_push;
    logic [LVL_W-1:0]      w_level_nx;

    always_comb begin
        w_slot_user = r_d1_user & r_d1_valid;
        // delayed valid falling: previous stage-1 valid now sits in r_out_valid
        w_eof       = ~r_d1_valid & r_out_valid;
        w_cur_shift = r_cur >> {r_idx, 2'b00};
        w_out_nib   = r_d1_nib;
        w_under     = 1'b0;
        w_idx_nx    = r_idx;
        w_clr       = 1'b0;
        if (w_slot_user) begin
            if (r_cur_v) begin
                w_out_nib = w_cur_shift[3:0];
                if (r_idx == IDX_W'(NN - 1)) begin
                    w_idx_nx = '0;
                    w_clr    = 1'b1;
                end else begin
                    w_idx_nx = r_idx + IDX_W'(1);
                end
            end else begin
                w_out_nib = PAD_NIBBLE;
                w_under   = 1'b1;
            end
        end
        if (w_eof && (ALIGN_DROP != 0) && (r_idx != '0)) begin
            w_idx_nx = '0;
            w_clr    = 1'b1;
        end
        // refill in the same cycle the current word is consumed or dropped
        w_pop      = ~(r_cur_v & ~w_clr) & (r_level != '0);
        w_push     = in_valid & r_in_ready;
        w_level_nx = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end

    always_ff @(posedge eth_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge eth_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_in_ready     <= 1'b0;
            r_d1_nib       <= '0;
            r_d1_user      <= 1'b0;
            r_d1_valid     <= 1'b0;
            r_out_nibble   <= '0;
            r_out_valid    <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
            r_start_send   <= 1'b0;
            r_cur          <= '0;
            r_cur_v        <= 1'b0;
            r_idx          <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level    <= w_level_nx;
            r_in_ready <= (w_level_nx != LVL_W'(DEPTH));

            r_d1_nib     <= nibble;
            r_d1_user    <= nibble_user_data;
            r_d1_valid   <= nibble_valid;
            r_out_nibble <= w_out_nib;
            r_out_valid  <= r_d1_valid;
            r_underrun   <= w_under;
            if (w_under && (r_underrun_cnt != 16'hFFFF))
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            // evaluated against next-cycle out_valid so it never overlaps a frame
            r_start_send <= ~r_d1_valid && (32'(w_level_nx) >= 32'(START_THRESH));

            r_idx <= w_idx_nx;
            if (w_pop) begin
                r_cur   <= r_mem[r_rd_ptr];
                r_cur_v <= 1'b1;
            end else if (w_clr) begin
                r_cur_v <= 1'b0;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_nibble   = r_out_nibble;
    assign out_valid    = r_out_valid;
    assign start_send   = r_start_send;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;
    assign level        = r_level;

endmodule

// File: tb/tb_nibble_payload_injector.sv
// Two injectors (resume vs. drop alignment) share one stimulus stream and are
// compared every cycle against a queue-based model of the merge rules.
module tb_nibble_payload_injector;

    localparam int          DW     = 8;
    localparam int          DL2    = 4;
    localparam int          DEPTH  = 16;
    localparam int          THRESH = 6;
    localparam int          NN     = DW / 4;
    localparam logic [3:0]  PAD    = 4'hD;

    logic          eth_clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [3:0]    nibble = '0;
    logic          nibble_user_data = 1'b0;
    logic          nibble_valid = 1'b0;

    logic          rdy  [2];
    logic [3:0]    onib [2];
    logic          ov   [2];
    logic          ss   [2];
    logic          und  [2];
    logic [15:0]   ucnt [2];
    logic [DL2:0]  lvl  [2];

    always #5 eth_clk = ~eth_clk;

    nibble_payload_injector #(.DATA_W(DW), .DEPTH_LOG2(DL2), .START_THRESH(THRESH),
                              .ALIGN_DROP(0), .PAD_NIBBLE(PAD)) u_dut0 (
        .eth_clk(eth_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .nibble(nibble), .nibble_user_data(nibble_user_data),
        .nibble_valid(nibble_valid), .out_nibble(onib[0]), .out_valid(ov[0]),
        .start_send(ss[0]), .underrun(und[0]), .underrun_cnt(ucnt[0]), .level(lvl[0]));

    nibble_payload_injector #(.DATA_W(DW), .DEPTH_LOG2(DL2), .START_THRESH(THRESH),
                              .ALIGN_DROP(1), .PAD_NIBBLE(PAD)) u_dut1 (
        .eth_clk(eth_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .nibble(nibble), .nibble_user_data(nibble_user_data),
        .nibble_valid(nibble_valid), .out_nibble(onib[1]), .out_valid(ov[1]),
        .start_send(ss[1]), .underrun(und[1]), .underrun_cnt(ucnt[1]), .level(lvl[1]));

    int n_vec = 0;
    int n_bad = 0;

    // reference state: payload FIFO as a ring, word in flight, nibble position
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_head [2];
    int            m_cnt  [2];
    logic [DW-1:0] m_cur  [2];
    bit            m_cur_v[2];
    int            m_idx  [2];
    logic [3:0]    m_onib [2];
    bit            m_und  [2];
    int            m_ucnt [2];
    bit            m_rdy  [2];
    bit            m_ss   [2];
    bit            m_ov;
    bit            p1_v, p1_u, p2_v;
    logic [3:0]    p1_n;
    logic [31:0]   seq_log [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_head[i] = 0; m_cnt[i] = 0; m_cur[i] = '0; m_cur_v[i] = 0; m_idx[i] = 0;
            m_onib[i] = '0; m_und[i] = 0; m_ucnt[i] = 0; m_rdy[i] = 0; m_ss[i] = 0;
        end
        m_ov = 0; p1_v = 0; p1_u = 0; p2_v = 0; p1_n = '0;
    endtask

    task automatic model_edge(input bit v, input bit u, input logic [3:0] n,
                              input bit iv, input logic [DW-1:0] d);
        logic [3:0] nout;
        bit         un;
        for (int i = 0; i < 2; i++) begin
            nout = p1_n;
            un   = 0;
            if (p1_u && p1_v) begin
                if (m_cur_v[i]) begin
                    nout = 4'(m_cur[i] >> (4 * m_idx[i]));
                    m_idx[i]++;
                    if (m_idx[i] == NN) begin
                        m_idx[i] = 0;
                        m_cur_v[i] = 0;
                    end
                end else begin
                    nout = PAD;
                    un   = 1;
                    if (m_ucnt[i] < 65535) m_ucnt[i]++;
                end
            end
            if (!p1_v && p2_v && i == 1 && m_idx[i] != 0) begin
                m_idx[i] = 0;
                m_cur_v[i] = 0;
            end
            if (!m_cur_v[i] && m_cnt[i] > 0) begin
                m_cur[i]   = m_mem[i][m_head[i]];
                m_head[i]  = (m_head[i] + 1) % DEPTH;
                m_cnt[i]--;
                m_cur_v[i] = 1;
            end
            if (iv && m_rdy[i]) begin
                m_mem[i][(m_head[i] + m_cnt[i]) % DEPTH] = d;
                m_cnt[i]++;
            end
            m_rdy[i]  = (m_cnt[i] < DEPTH);
            m_onib[i] = nout;
            m_und[i]  = un;
            m_ss[i]   = !p1_v && (m_cnt[i] >= THRESH);
        end
        m_ov = p1_v;
        p2_v = p1_v; p1_v = v; p1_u = u; p1_n = n;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_out_nibble", i), 32'(onib[i]), 32'(m_onib[i]));
            chk($sformatf("d%0d_out_valid", i), 32'(ov[i]), 32'(m_ov));
            chk($sformatf("d%0d_underrun", i), 32'(und[i]), 32'(m_und[i]));
            chk($sformatf("d%0d_underrun_cnt", i), 32'(ucnt[i]), 32'(m_ucnt[i]));
            chk($sformatf("d%0d_level", i), 32'(lvl[i]), 32'(m_cnt[i]));
            chk($sformatf("d%0d_in_ready", i), 32'(rdy[i]), 32'(m_rdy[i]));
            chk($sformatf("d%0d_start_send", i), 32'(ss[i]), 32'(m_ss[i]));
            if (ov[i] === 1'b1) seq_log[i] = {seq_log[i][27:0], onib[i]};
        end
    endtask

    task automatic step(input bit v, input bit u, input logic [3:0] n,
                        input bit iv, input logic [DW-1:0] d);
        nibble_valid = v; nibble_user_data = u; nibble = n;
        in_valid = iv; in_data = d;
        model_edge(v, u, n, iv, d);
        @(posedge eth_clk);
        @(negedge eth_clk);
        check_all();
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(0, 0, 4'(k), 0, '0);
    endtask

    // called at a falling edge; checks the asynchronous clear immediately
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        for (int k = 0; k < 2; k++) begin
            @(posedge eth_clk);
            @(negedge eth_clk);
            check_all();
        end
        rst = 1'b0;
        in_valid = 0; nibble_valid = 0; nibble_user_data = 0;
        chk("rdy_low_before_edge", 32'(rdy[0]), 32'd0);
        step(0, 0, 4'h0, 0, '0);
        chk("rdy_high_after_edge", 32'(rdy[1]), 32'd1);
        seq_log[0] = '0;
        seq_log[1] = '0;
    endtask

    initial begin
        @(negedge eth_clk);
        do_reset();

        // two words, one four-slot frame
        step(0, 0, 4'h0, 1, 8'hA5);
        step(0, 0, 4'h0, 1, 8'h3C);
        step(0, 0, 4'h0, 0, '0);
        for (int k = 0; k < 4; k++) step(1, 1, 4'h0, 0, '0);
        idle(3);
        chk("seq_a5_3c_d0", seq_log[0], 32'h5AC3);
        chk("seq_a5_3c_d1", seq_log[1], 32'h5AC3);
        chk("level_drained", 32'(lvl[0]), 32'd0);

        // underrun on an empty FIFO, then a late word starts at nibble 0
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 1, 4'h0, 0, '0);
        idle(3);
        chk("underrun_cnt3", 32'(ucnt[1]), 32'd3);
        step(0, 0, 4'h0, 1, 8'h7E);
        idle(1);
        step(1, 1, 4'h0, 0, '0);
        step(1, 1, 4'h0, 0, '0);
        idle(3);
        chk("seq_underrun_d0", seq_log[0], 32'hDDDE7);

        // frame ends one nibble into 8'h12: resume vs. drop
        do_reset();
        step(0, 0, 4'h0, 1, 8'h12);
        step(0, 0, 4'h0, 1, 8'h34);
        step(0, 0, 4'h0, 0, '0);
        step(1, 1, 4'h0, 0, '0);
        idle(2);
        step(1, 1, 4'h0, 0, '0);
        step(1, 1, 4'h0, 0, '0);
        idle(3);
        chk("seq_resume_d0", seq_log[0], 32'h214);
        chk("seq_drop_d1", seq_log[1], 32'h243);

        // mixed user/non-user slots
        step(0, 0, 4'h0, 1, 8'hF0);
        step(1, 0, 4'h1, 0, '0);
        step(1, 0, 4'h2, 0, '0);
        for (int k = 0; k < 3; k++) step(1, 1, 4'h0, 0, '0);
        idle(3);

        // fill to full, then push and pop together during a long frame
        do_reset();
        for (int k = 0; k < DEPTH + 4; k++) step(0, 0, 4'h0, 1, 8'(k * 17 + 3));
        chk("full_level", 32'(lvl[0]), 32'(DEPTH));
        chk("full_in_ready", 32'(rdy[1]), 32'd0);
        chk("full_start_send", 32'(ss[0]), 32'd1);
        for (int k = 0; k < 24; k++) step(1, 1, 4'h0, 1, 8'($urandom));
        idle(4);

        // randomized frames, gaps, pushes and occasional mid-frame resets
        for (int f = 0; f < 150; f++) begin
            int gap, len, rst_at, push_pct;
            gap      = $urandom_range(1, 4);
            len      = $urandom_range(1, 12);
            rst_at   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len - 1) : -1;
            push_pct = $urandom_range(10, 90);
            for (int k = 0; k < gap; k++)
                step(0, 1'($urandom), 4'($urandom),
                     ($urandom_range(0, 99) < push_pct), 8'($urandom));
            for (int k = 0; k < len; k++) begin
                if (k == rst_at) do_reset();
                step(1, ($urandom_range(0, 99) < 65), 4'($urandom),
                     ($urandom_range(0, 99) < push_pct), 8'($urandom));
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_payload_injector.md
NIBBLE_PAYLOAD_INJECTOR -- requirements
Module: nibble_payload_injector

Interface
REQ-001 Parameter DATA_W, default 8: payload word width in bits; SHALL be a multiple of 4 in the range 4..32.
REQ-002 Parameter DEPTH_LOG2, default 10: internal FIFO depth is 2^DEPTH_LOG2 words.
REQ-003 Parameter START_THRESH, default 512: FIFO occupancy in words at or above which a send is requested.
REQ-004 Parameter ALIGN_DROP, default 1: 1 discards a partly sent word at end of frame; 0 resumes it in the next frame.
REQ-005 Parameter PAD_NIBBLE, default 4'h0: nibble emitted into a user slot on underrun.
REQ-006 eth_clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  payload word offered.
REQ-009 in_data  in  DATA_W  payload word; nibble 0 is bits [3:0] and is sent first.
REQ-010 in_ready  out  1  FIFO can accept a word.
REQ-011 nibble / nibble_user_data / nibble_valid  in  4/1/1  upstream frame nibble stream; user_data marks a payload slot.
REQ-012 out_nibble / out_valid  out  4/1  merged stream.
REQ-013 start_send  out  1  request to the frame generator.
REQ-014 underrun  out  1  one-cycle pulse per padded slot.
REQ-015 underrun_cnt  out  16  saturating count of padded slots.
REQ-016 level  out  DEPTH_LOG2+1  FIFO occupancy in words.

Function
REQ-017 The write is accepted when in_valid=1 and in_ready=1; in_ready SHALL be !full, registered, with no combinational path from in_valid.
REQ-018 A simultaneous push and pop SHALL leave level unchanged; level SHALL never exceed 2^DEPTH_LOG2 or wrap below 0.
REQ-019 A prefetch register cur (DATA_W bits) with flag cur_v SHALL load from the FIFO head whenever cur_v=0 and the FIFO is non-empty, including in the same cycle in which cur_v is cleared.
REQ-020 Latency: out_nibble and out_valid SHALL equal the input stream delayed by exactly 2 eth_clk cycles; out_valid is nibble_valid delayed by 2.
REQ-021 Non-user slot (nibble_user_data=0): out_nibble SHALL be the input nibble unchanged.
REQ-022 User slot with cur_v=1: out_nibble SHALL be cur[4*idx+:4], where idx is the nibble index in 0..DATA_W/4-1.
REQ-023 After the nibble at idx=DATA_W/4-1, idx SHALL wrap to 0 and cur_v SHALL clear; otherwise idx increments by 1.
REQ-024 User slot with cur_v=0: out_nibble SHALL be PAD_NIBBLE and underrun SHALL pulse aligned with that output nibble.
REQ-025 On underrun, idx SHALL be unchanged and underrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-026 End of frame is an input nibble_valid 1->0 transition.
REQ-027 At end of frame with ALIGN_DROP=1 and idx!=0, idx SHALL reset to 0 and cur_v SHALL clear, discarding the word remainder.
REQ-028 At end of frame with ALIGN_DROP=0, idx and cur SHALL be held for the next frame.
REQ-029 start_send SHALL be registered as (nibble_valid delayed by 2 == 0) AND (level >= START_THRESH).
REQ-030 start_send SHALL be 0 while the delayed frame is active.
REQ-031 A user slot arriving while nibble_valid=0 SHALL be treated as a non-user slot.

Reset
REQ-032 While rst=1: FIFO flushed, level=0, cur_v=0, idx=0, in_ready=0, out_nibble=0, out_valid=0, start_send=0, underrun=0, underrun_cnt=0.
REQ-033 The 2-stage delay pipeline SHALL be cleared by reset.
REQ-034 in_ready SHALL rise on the first eth_clk edge after rst deasserts.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no partial word retained.

Verification
REQ-036 DATA_W=8; push 8'hA5, 8'h3C; frame of 4 user slots -> out_nibble 5,A,C,3 at cycle+2; level returns to 0.
REQ-037 DATA_W=16; frame with non-user nibbles 1,2 then 4 user slots, FIFO holds 16'hBEEF -> output 1,2,F,E,E,B; no underrun.
REQ-038 FIFO empty; 3 user slots -> 3 PAD_NIBBLE outputs, 3 underrun pulses, underrun_cnt=3; word pushed later is sent from its nibble 0.
REQ-039 DATA_W=8, ALIGN_DROP=1; frame ends after 1 nibble of 8'h12 -> next frame starts with the next word. Repeat with ALIGN_DROP=0 -> next frame starts with nibble 1.
REQ-040 Fill to 2^DEPTH_LOG2 -> in_ready=0 and level at maximum; push+pop in the same cycle -> level constant; start_send=1 only in idle cycles with level>=START_THRESH.
